div_rem_seq_unit: RTL and testbench

//  Parametrised multi-cycle RISC-V M-extension divider for DIV/DIVU/REM/REMU.

---
 rtl/div_rem_seq_unit.sv | 142 ++++++++++++++
 tb/tb_div_rem_seq_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div_rem_seq_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow skip the iteration and go straight to DONE.
module div_rem_seq_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned COUNT_WIDTH = $clog2(XLEN)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]        MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] LAST_ITER = COUNT_WIDTH'(XLEN - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [XLEN-1:0]        quot;
  logic [XLEN-1:0]        rem;
  logic [XLEN-1:0]        dvsr;
  logic                   is_rem;
  logic                   neg_q;
  logic                   neg_r;
  logic [TAG_W-1:0]       tag_q;

  logic                   signed_op_c;
  logic                   dvd_neg_c;
  logic                   dvs_neg_c;
  logic                   div_zero_c;
  logic                   overflow_c;
  logic [XLEN-1:0]        dvd_mag_c;
  logic [XLEN-1:0]        dvs_mag_c;
  logic [XLEN-1:0]        fast_res_c;
  logic [XLEN:0]          shifted_c;
  logic                   trial_ok_c;
  logic [XLEN-1:0]        diff_c;
  logic [XLEN-1:0]        q_fix_c;
  logic [XLEN-1:0]        r_fix_c;

  // Operand decode at accept: magnitudes, sign info and the special cases
  assign signed_op_c = ~op[0];
  assign dvd_neg_c   = signed_op_c & dividend[XLEN-1];
  assign dvs_neg_c   = signed_op_c & divisor[XLEN-1];
  assign dvd_mag_c   = dvd_neg_c ? -dividend : dividend;
  assign dvs_mag_c   = dvs_neg_c ? -divisor : divisor;
  assign div_zero_c  = (divisor == '0);
  assign overflow_c  = signed_op_c & (dividend == MIN_NEG) & (divisor == '1);
  assign fast_res_c  = div_zero_c ? (op[1] ? dividend : '1)
                                  : (op[1] ? '0 : dividend);

  // One restoring step; the shifted remainder needs XLEN+1 bits for large divisors
  assign shifted_c   = {rem, quot[XLEN-1]};
  assign trial_ok_c  = (shifted_c >= {1'b0, dvsr});
  assign diff_c      = shifted_c[XLEN-1:0] - dvsr;

  assign q_fix_c     = neg_q ? -quot : quot;
  assign r_fix_c     = neg_r ? -rem : rem;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      counter   <= '0;
      quot      <= '0;
      rem       <= '0;
      dvsr      <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      tag_q     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            is_rem   <= op[1];
            neg_q    <= dvd_neg_c ^ dvs_neg_c;
            neg_r    <= dvd_neg_c;
            tag_q    <= in_tag;
            quot     <= dvd_mag_c;
            rem      <= '0;
            dvsr     <= dvs_mag_c;
            counter  <= '0;
            if (div_zero_c || overflow_c) begin
              result    <= fast_res_c;
              out_tag   <= in_tag;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= trial_ok_c ? diff_c : shifted_c[XLEN-1:0];
          quot    <= {quot[XLEN-2:0], trial_ok_c};
          counter <= counter + COUNT_WIDTH'(1);
          if (counter == LAST_ITER) state <= FIX;
        end
        FIX: begin
          result    <= is_rem ? r_fix_c : q_fix_c;
          out_tag   <= tag_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_seq_unit.sv
// Bench for div_rem_seq_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_rem_seq_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic             CLK;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  div_rem_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // RISC-V M semantics in plain arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      OP_DIV:  return 32'($signed(a) / $signed(b));
      OP_DIVU: return a / b;
      OP_REM:  return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Reference model: one op in flight, result due m_lat cycles after accept
  int          cyc = 0;
  int          acc_cyc = 0;
  int          m_lat = 0;
  bit          m_busy = 1'b0;
  bit          m_valid;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;

  always @(negedge CLK) begin
    cyc++;
    m_valid = m_busy && ((cyc - acc_cyc) >= m_lat);
    check("mdl out_valid", 32'(out_valid), 32'(m_valid));
    check("mdl in_ready", 32'(in_ready), 32'(!m_busy));
    check("mdl busy", 32'(busy), 32'(m_busy));
    if (m_valid) begin
      check("mdl result", result, m_res);
      check("mdl out_tag", 32'(out_tag), 32'(m_tag));
    end
    if (rst || flush) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  = 1'b1;
        acc_cyc = cyc;
        m_res   = ref_res(op, dividend, divisor);
        m_tag   = in_tag;
        m_lat   = ref_lat(op, dividend, divisor);
      end
    end else if (m_valid && out_ready) begin
      m_busy = 1'b0;
    end
  end

  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    @(posedge CLK); #1;
    in_valid = 1'b1; op = o; dividend = a; divisor = b; in_tag = t;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    in_tag   = 5'($urandom);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    bit got;
    start(o, a, b, t);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge CLK);
      lat++;
      got = out_valid;
    end
    check({name, " seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
    check({name, " tag"}, 32'(out_tag), 32'(t));
    repeat (hold + 1) @(posedge CLK);
    #1;
    if (hold > 0) begin
      check({name, " held result"}, result, exp);
      check({name, " held tag"}, 32'(out_tag), 32'(t));
      check({name, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({name, " drop"}, 32'(out_valid), 32'd0);
    check({name, " idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    check("reset result", result, 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);

    run_op("T1 divu", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34, 0);
    run_op("T2 div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34, 0);
    run_op("T2 rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("T2 rem pos", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 34, 0);
    run_op("T3 divu0", OP_DIVU, 32'h1234, 32'd0, 5'd5, 32'hFFFF_FFFF, 1, 0);
    run_op("T3 div0", OP_DIV, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 1, 0);
    run_op("T3 remu0", OP_REMU, 32'h1234, 32'd0, 5'd7, 32'h1234, 1, 0);
    run_op("T3 rem0", OP_REM, 32'h1234, 32'd0, 5'd8, 32'h1234, 1, 0);
    run_op("T4 div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, 0);
    run_op("T4 rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1, 0);
    run_op("divu max", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, 32'd1, 34, 0);
    run_op("remu max", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h7FFF_FFFE, 34, 0);
    run_op("div neg", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFF2, 34, 0);
    run_op("rem neg", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFFE, 34, 0);
    run_op("div min/2", OP_DIV, 32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, 34, 0);
    run_op("T5 backpressure", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 34, 10);

    // Flush in the fifth CALC cycle
    start(OP_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (4) @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    check("T6 flush out_valid", 32'(out_valid), 32'd0);
    check("T6 flush in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(posedge CLK);

    // Reset mid-CALC clears the registered outputs
    start(OP_DIV, 32'hFFFF_FFCE, 32'd5, 5'd11);
    repeat (10) @(posedge CLK);
    #1 rst = 1'b1;
    @(posedge CLK); #1 rst = 1'b0;
    check("T6 rst result", result, 32'd0);
    check("T6 rst out_tag", 32'(out_tag), 32'd0);
    check("T6 rst in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(posedge CLK);
    run_op("T6 divu after", OP_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 34, 0);

    // Flush beats out_ready on a pending result
    start(OP_DIVU, 32'd5, 32'd0, 5'd4);
    check("flush done valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1 flush = 1'b0; out_ready = 1'b0;
    check("flush done dropped", 32'(out_valid), 32'd0);
    check("flush done idle", 32'(in_ready), 32'd1);

    // Flush beats in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; op = OP_DIVU; dividend = 32'd8; divisor = 32'd2;
    @(posedge CLK); #1 in_valid = 1'b0; flush = 1'b0;
    check("flush idle no accept", 32'(busy), 32'd0);
    repeat (3) @(posedge CLK);

    run_op("final remu", OP_REMU, 32'd1000, 32'd7, 5'd30, 32'd6, 34, 2);
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
